mfcc_streamer: RTL and testbench

MFCC_STREAMER -- requirements
Module: mfcc_streamer

---
 rtl/mfcc_streamer.sv | 131 +++++++++++++
 tb/tb_mfcc_streamer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_streamer.sv
// rtl/mfcc_streamer.sv - two-slot MFCC frame buffer streaming one coefficient per handshake
//
// Ports:
//   clk, rst_n        single clock, synchronous active-low reset
//   mfcc_done_i       one-cycle frame-complete pulse from the MFCC core
//   mfcc_data_i       NUM_COEFS*COEF_W coefficient vector, coef k at [k*COEF_W +: COEF_W]
//   coef_o            current streamed coefficient
//   coef_idx_o        index of coef_o within its frame
//   frame_id_o        tag of the frame being streamed
//   valid_o, ready_i  output word valid / downstream ready
//   first_o, last_o   flag coefficient 0 / coefficient NUM_COEFS-1
//   pending_o         number of buffered frames (0..2)
//   drop_cnt_o        saturating count of frames dropped on a full buffer
module mfcc_streamer #(
    parameter int NUM_COEFS = 13,
    parameter int COEF_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mfcc_done_i,
    input  logic [NUM_COEFS*COEF_W-1:0] mfcc_data_i,
    output logic [COEF_W-1:0]           coef_o,
    output logic [3:0]                  coef_idx_o,
    output logic [7:0]                  frame_id_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        first_o,
    output logic                        last_o,
    output logic [1:0]                  pending_o,
    output logic [15:0]                 drop_cnt_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;
    localparam logic [3:0] LAST_IDX  = 4'(NUM_COEFS - 1);

    logic [NUM_COEFS*COEF_W-1:0] slot_data [2];
    logic [7:0]                  slot_tag  [2];

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic [3:0]  idx;
    logic [7:0]  tag_cnt;
    logic [15:0] drop_cnt;

    logic        hs;
    logic        last_hs;
    logic        accept;
    logic        drop;
    logic [NUM_COEFS*COEF_W-1:0] cur_frame;

    assign valid_o = (state == ST_STREAM);
    assign hs      = valid_o && ready_i;
    assign last_hs = hs && (idx == LAST_IDX);

    // A full buffer still accepts when the final word of the read slot
    // leaves in the same cycle: the incoming frame lands in the freed slot.
    assign accept = mfcc_done_i && ((count != 2'd2) || last_hs);
    assign drop   = mfcc_done_i && (count == 2'd2) && !last_hs;

    always_comb begin
        count_next = count + {1'b0, accept} - {1'b0, last_hs};
        state_next = (count_next != 2'd0) ? ST_STREAM : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            idx      <= 4'd0;
            tag_cnt  <= 8'd0;
            drop_cnt <= 16'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (mfcc_done_i) begin
                tag_cnt <= tag_cnt + 8'd1;
            end
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (hs) begin
                if (last_hs) begin
                    idx    <= 4'd0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

    // Slot storage needs no reset; the pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            slot_data[wr_ptr] <= mfcc_data_i;
            slot_tag[wr_ptr]  <= tag_cnt;
        end
    end

    assign cur_frame = slot_data[rd_ptr];

    // Outputs are forced to zero when nothing is valid so reset and idle read clean.
    always_comb begin
        coef_o     = '0;
        coef_idx_o = 4'd0;
        frame_id_o = 8'd0;
        first_o    = 1'b0;
        last_o     = 1'b0;
        if (valid_o) begin
            coef_o     = cur_frame[32'(idx)*COEF_W +: COEF_W];
            coef_idx_o = idx;
            frame_id_o = slot_tag[rd_ptr];
            first_o    = (idx == 4'd0);
            last_o     = (idx == LAST_IDX);
        end
    end

    assign pending_o  = count;
    assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_mfcc_streamer.sv
// tb/tb_mfcc_streamer.sv - directed self-checking bench for mfcc_streamer
module tb_mfcc_streamer;

    localparam int NC = 13;
    localparam int CW = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mfcc_done_i;
    logic [NC*CW-1:0]   mfcc_data_i;
    logic [CW-1:0]      coef_o;
    logic [3:0]         coef_idx_o;
    logic [7:0]         frame_id_o;
    logic               valid_o;
    logic               ready_i;
    logic               first_o;
    logic               last_o;
    logic [1:0]         pending_o;
    logic [15:0]        drop_cnt_o;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mfcc_streamer #(.NUM_COEFS(NC), .COEF_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mfcc_done_i (mfcc_done_i),
        .mfcc_data_i (mfcc_data_i),
        .coef_o      (coef_o),
        .coef_idx_o  (coef_idx_o),
        .frame_id_o  (frame_id_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .first_o     (first_o),
        .last_o      (last_o),
        .pending_o   (pending_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    typedef struct {
        logic        done;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_coef;
        logic [3:0]  exp_idx;
        logic        exp_first;
        logic        exp_last;
        logic [1:0]  exp_pending;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NC*CW-1:0] mk_frame(input logic [15:0] base);
        logic [NC*CW-1:0] f;
        f = '0;
        for (int k = 0; k < NC; k++) f[k*CW +: CW] = base + 16'(k);
        return f;
    endfunction

    // Inputs are set before calling; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mfcc_done_i = 1'b0;
        ready_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Drain one frame with ready=1; checks its tag, base value and index order.
    task automatic drain_frame(input string name, input logic [7:0] exp_tag, input logic [15:0] base);
        ready_i = 1'b1;
        mfcc_done_i = 1'b0;
        chk({name, "_valid"}, 32'(valid_o), 32'd1);
        chk({name, "_tag"}, 32'(frame_id_o), 32'(exp_tag));
        for (int k = 0; k < NC; k++) begin
            if (coef_o !== base + 16'(k) || coef_idx_o !== 4'(k)) begin
                chk({name, "_word"}, {coef_o, 12'd0, coef_idx_o}, {base + 16'(k), 12'd0, 4'(k)});
            end
            step();
        end
        tests++;
    endtask

    initial begin
        int k_exp;
        int cyc;
        logic [15:0] held_coef;
        logic [3:0]  held_idx;
        logic        was_stall;
        logic [3:0]  pat;

        mfcc_data_i = '0;
        do_reset();

        // reset state
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_pending", 32'(pending_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("rst_coef", {coef_o, coef_idx_o, frame_id_o}, 32'd0);

        // single frame table
        vecs[0] = '{1'b1, 1'b1, 1'b1, 16'h0100, 4'd0, 1'b1, 1'b0, 2'd1};
        for (int i = 1; i <= 12; i++)
            vecs[i] = '{1'b0, 1'b1, 1'b1, 16'h0100 + 16'(i), 4'(i), 1'b0, (i == 12), 2'd1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 2'd0};

        mfcc_data_i = mk_frame(16'h0100);
        for (int i = 0; i < 14; i++) begin
            mfcc_done_i = vecs[i].done;
            ready_i     = vecs[i].ready;
            step();
            chk($sformatf("sf%0d_valid", i), 32'(valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("sf%0d_coef", i), 32'(coef_o), 32'(vecs[i].exp_coef));
            chk($sformatf("sf%0d_idx", i), 32'(coef_idx_o), 32'(vecs[i].exp_idx));
            chk($sformatf("sf%0d_first", i), 32'(first_o), 32'(vecs[i].exp_first));
            chk($sformatf("sf%0d_last", i), 32'(last_o), 32'(vecs[i].exp_last));
            chk($sformatf("sf%0d_pend", i), 32'(pending_o), 32'(vecs[i].exp_pending));
            if (vecs[i].exp_valid) chk($sformatf("sf%0d_tag", i), 32'(frame_id_o), 32'd0);
        end

        // backpressure: ready pattern 1,0,0,1
        do_reset();
        pat = 4'b1001;
        mfcc_data_i = mk_frame(16'h0200);
        mfcc_done_i = 1'b1;
        step();
        mfcc_done_i = 1'b0;
        k_exp = 0;
        cyc = 0;
        was_stall = 1'b0;
        held_coef = '0;
        held_idx = '0;
        while (k_exp < NC && cyc < 200) begin
            ready_i = pat[cyc % 4];
            if (was_stall) begin
                chk("bp_hold", {coef_o, 12'd0, coef_idx_o}, {held_coef, 12'd0, held_idx});
            end
            if (!valid_o) begin
                chk("bp_valid_drop", 32'(valid_o), 32'd1);
                k_exp = NC;
            end else if (ready_i) begin
                chk("bp_word", {coef_o, 12'd0, coef_idx_o}, {16'h0200 + 16'(k_exp), 12'd0, 4'(k_exp)});
                k_exp++;
                was_stall = 1'b0;
            end else begin
                held_coef = coef_o;
                held_idx = coef_idx_o;
                was_stall = 1'b1;
            end
            step();
            cyc++;
        end
        chk("bp_timeout", 32'(cyc < 200), 32'd1);
        chk("bp_end_valid", 32'(valid_o), 32'd0);

        // overflow: three dones while stalled
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mfcc_data_i = mk_frame(16'h1000 * 16'(i + 1));
            mfcc_done_i = 1'b1;
            step();
        end
        mfcc_done_i = 1'b0;
        chk("ov_pending", 32'(pending_o), 32'd2);
        chk("ov_drop", 32'(drop_cnt_o), 32'd1);
        drain_frame("ov_f0", 8'd0, 16'h1000);
        drain_frame("ov_f1", 8'd1, 16'h2000);
        chk("ov_empty", 32'(pending_o), 32'd0);
        mfcc_data_i = mk_frame(16'h4000);
        mfcc_done_i = 1'b1;
        step();
        drain_frame("ov_f3", 8'd3, 16'h4000);

        // simultaneous done and final handshake with a full buffer
        do_reset();
        for (int i = 0; i < 2; i++) begin
            mfcc_data_i = mk_frame(16'h5000 + 16'h1000 * 16'(i));
            mfcc_done_i = 1'b1;
            step();
        end
        mfcc_done_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < NC - 1; i++) step();
        chk("sim_at_last", 32'(last_o), 32'd1);
        mfcc_data_i = mk_frame(16'h7000);
        mfcc_done_i = 1'b1;
        step();
        mfcc_done_i = 1'b0;
        chk("sim_pending", 32'(pending_o), 32'd2);
        chk("sim_drop", 32'(drop_cnt_o), 32'd0);
        drain_frame("sim_f1", 8'd1, 16'h6000);
        drain_frame("sim_f2", 8'd2, 16'h7000);

        // reset at coefficient 5 with a done pulse coincident with reset
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mfcc_data_i = mk_frame(16'h0300);
            mfcc_done_i = 1'b1;
            step();
        end
        mfcc_done_i = 1'b0;
        chk("rm_drop_pre", 32'(drop_cnt_o), 32'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("rm_idx5", 32'(coef_idx_o), 32'd5);
        rst_n = 1'b0;
        mfcc_done_i = 1'b1;
        step();
        rst_n = 1'b1;
        mfcc_done_i = 1'b0;
        chk("rm_valid", 32'(valid_o), 32'd0);
        chk("rm_pending", 32'(pending_o), 32'd0);
        chk("rm_drop", 32'(drop_cnt_o), 32'd0);
        step();
        chk("rm_still_idle", 32'(valid_o), 32'd0);
        mfcc_data_i = mk_frame(16'h0800);
        mfcc_done_i = 1'b1;
        step();
        drain_frame("rm_next", 8'd0, 16'h0800);

        // drop counter saturation
        do_reset();
        ready_i = 1'b0;
        mfcc_done_i = 1'b1;
        for (int i = 0; i < 2 + 65535; i++) step();
        chk("sat_ffff", 32'(drop_cnt_o), 32'h0000FFFF);
        step();
        chk("sat_hold", 32'(drop_cnt_o), 32'h0000FFFF);
        mfcc_done_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
